axis_port_rr_arbiter: RTL and testbench
=======================================

AXIS_PORT_RR_ARBITER -- requirements
Module: axis_port_rr_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_PORT, 2, number of RX CMAC-side input streams (1..16)
- DATA_WIDTH, 512, AXIS data width
- KEEP_WIDTH, 64, AXIS keep width
REQ-002 Ports SHALL be:
- axis_aclk  in  1  single clock for all logic
- box_rstn  in  1  asynchronous active-low reset
- s_axis_tvalid  in  NUM_PORT  per-port valid
- s_axis_tdata  in  DATA_WIDTH*NUM_PORT  per-port data, port i at slice i
- s_axis_tkeep  in  KEEP_WIDTH*NUM_PORT  per-port keep
- s_axis_tlast  in  NUM_PORT  per-port last
- s_axis_tuser_size/src/dst  in  16*NUM_PORT each  per-port sideband
- s_axis_tready  out  NUM_PORT  per-port ready
- m_axis_tvalid/tdata/tkeep/tlast/tuser_size/src/dst  out  1/DATA_WIDTH/KEEP_WIDTH/1/16/16/16  merged stream to packet filter
- m_axis_tready  in  1  downstream ready
- m_axis_port  out  4  index of port currently granted
- arb_en  in  1  1 = new grants permitted
- busy  out  1  1 while a packet is in transfer

Function
REQ-003 FSM SHALL have states IDLE and XFER.
REQ-004 IDLE: m_axis_tvalid=0, all s_axis_tready=0, busy=0.
REQ-005 IDLE with arb_en=1 and any s_axis_tvalid=1: register grant = first port with tvalid=1 searching last_grant+1, last_grant+2, ... modulo NUM_PORT; next state XFER.
REQ-006 XFER: m_axis_* SHALL equal granted port's s_axis_* combinationally (zero latency); s_axis_tready[grant]=m_axis_tready; all other s_axis_tready=0; busy=1.
REQ-007 XFER: beat with m_axis_tvalid & m_axis_tready & m_axis_tlast -> IDLE, last_grant<=grant.
REQ-008 Arbitration bubble: exactly one idle cycle between consecutive packets.
REQ-009 Grant SHALL be held for whole packet; granted-port tvalid dropping mid-packet keeps XFER, m_axis_tvalid follows it.
REQ-010 arb_en deassert mid-packet SHALL NOT abort; current packet completes, then no new grant.
REQ-011 Single-beat packet (tlast on first beat) SHALL return to IDLE after that beat.
REQ-012 NUM_PORT=1: grant always 0, behaviour otherwise identical.
REQ-013 m_axis_port SHALL show registered grant in all states (zero-extended).

Reset
REQ-014 box_rstn=0 SHALL asynchronously force state IDLE, grant=0, last_grant=NUM_PORT-1, m_axis_tvalid=0, all s_axis_tready=0, busy=0, counters 0.
REQ-015 Reset mid-packet SHALL abort the packet; no partial-packet recovery; first grant after reset goes to lowest valid index.

Configuration
REQ-016 Macro PORT_ARB_STATS_EN defined: output pkt_cnt (32*NUM_PORT) with per-port 32-bit counters incrementing on each tlast handshake of that port, wrapping 0xFFFFFFFF->0; undefined: port and counters absent, no other change.

Verification
REQ-017 Bench SHALL cover:
- All 2 ports continuously valid, 3-beat packets, tready=1 -> grants 0,1,0,1; one bubble between packets; m_axis_port matches.
- Only port 1 valid, 4 single-beat packets -> four grants to port 1, each separated by one idle cycle.
- Port 0 packet 5 beats, m_axis_tready toggled 1/0 each cycle -> 5 beats delivered in order, port 1 s_axis_tready held 0 throughout.
- arb_en=0 at beat 2 of 4-beat packet -> packet completes; state IDLE; no grant while arb_en=0 despite valid requests.
- box_rstn pulsed at beat 2 of packet on port 1 -> m_axis_tvalid=0 immediately; after release, port 0 and 1 valid -> port 0 granted first.
- PORT_ARB_STATS_EN, port 0 counter preloaded 0xFFFFFFFF via force, one packet -> pkt_cnt[0]=0.

Source files
------------

// File: rtl/axis_port_rr_arbiter_if.sv
// Bundle of per-port AXI-Stream inputs and the merged AXI-Stream output
// for axis_port_rr_arbiter.
//   master : the side that drives the per-port streams and consumes the
//            merged stream (sources plus downstream sink).
//   slave  : the arbiter itself.
interface axis_port_rr_arbiter_if #(
  parameter int NUM_PORT   = 2,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64
) ();

  // Per-port input streams, port i occupies slice i of each vector
  logic [NUM_PORT-1:0]            s_axis_tvalid;
  logic [DATA_WIDTH*NUM_PORT-1:0] s_axis_tdata;
  logic [KEEP_WIDTH*NUM_PORT-1:0] s_axis_tkeep;
  logic [NUM_PORT-1:0]            s_axis_tlast;
  logic [16*NUM_PORT-1:0]         s_axis_tuser_size;
  logic [16*NUM_PORT-1:0]         s_axis_tuser_src;
  logic [16*NUM_PORT-1:0]         s_axis_tuser_dst;
  logic [NUM_PORT-1:0]            s_axis_tready;

  // Merged output stream toward the packet filter
  logic                           m_axis_tvalid;
  logic [DATA_WIDTH-1:0]          m_axis_tdata;
  logic [KEEP_WIDTH-1:0]          m_axis_tkeep;
  logic                           m_axis_tlast;
  logic [15:0]                    m_axis_tuser_size;
  logic [15:0]                    m_axis_tuser_src;
  logic [15:0]                    m_axis_tuser_dst;
  logic                           m_axis_tready;

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
           s_axis_tuser_size, s_axis_tuser_src, s_axis_tuser_dst,
    input  s_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
           m_axis_tuser_size, m_axis_tuser_src, m_axis_tuser_dst,
    output m_axis_tready
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
           s_axis_tuser_size, s_axis_tuser_src, s_axis_tuser_dst,
    output s_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
           m_axis_tuser_size, m_axis_tuser_src, m_axis_tuser_dst,
    input  m_axis_tready
  );

endinterface

// File: rtl/axis_port_rr_arbiter.sv
// Round-robin packet arbiter merging NUM_PORT AXI-Stream inputs into one
// output stream. A grant is taken in IDLE and held for a whole packet; the
// granted port is forwarded combinationally while in XFER. Every packet is
// followed by exactly one IDLE (arbitration) cycle.
//
// Optional feature: define PORT_ARB_STATS_EN to add output pkt_cnt with one
// wrapping 32-bit packet counter per port.
module axis_port_rr_arbiter #(
  parameter int NUM_PORT   = 2,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64
) (
  input  logic                         axis_aclk,
  input  logic                         box_rstn,
  axis_port_rr_arbiter_if.slave        axis,
  input  logic                         arb_en,
  output logic [3:0]                   m_axis_port,
  output logic                         busy
`ifdef PORT_ARB_STATS_EN
  ,
  output logic [32*NUM_PORT-1:0]       pkt_cnt
`endif
);

  // Last port served before reset, so the first search starts at port 0
  localparam logic [3:0] LAST_GRANT_INIT = 4'(NUM_PORT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  last_grant_q, last_grant_d;

  logic [15:0] valid_ext;
  logic [4:0]  rr_cand;
  logic [3:0]  rr_pick;
  logic        rr_found;

  logic                  sel_tvalid;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic [KEEP_WIDTH-1:0] sel_tkeep;
  logic                  sel_tlast;
  logic [15:0]           sel_size;
  logic [15:0]           sel_src;
  logic [15:0]           sel_dst;

  logic                  xfer;
  logic                  last_beat;

  assign xfer      = (state_q == ST_XFER);
  assign last_beat = xfer & sel_tvalid & axis.m_axis_tready & sel_tlast;

  // Round-robin search: first requesting port after last_grant, wrapping
  always_comb begin
    valid_ext = 16'(axis.s_axis_tvalid);
    rr_found  = 1'b0;
    rr_pick   = 4'd0;
    rr_cand   = 5'd0;
    for (int k = 1; k <= NUM_PORT; k++) begin
      rr_cand = {1'b0, last_grant_q} + 5'(k);
      if (rr_cand >= 5'(NUM_PORT)) begin
        rr_cand = rr_cand - 5'(NUM_PORT);
      end else begin
        rr_cand = rr_cand;
      end
      if (!rr_found && valid_ext[rr_cand[3:0]]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand[3:0];
      end else begin
        rr_found = rr_found;
      end
    end
  end

  // AND-OR multiplexer selecting the granted port's stream fields
  always_comb begin
    sel_tvalid = 1'b0;
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tlast  = 1'b0;
    sel_size   = 16'd0;
    sel_src    = 16'd0;
    sel_dst    = 16'd0;
    for (int i = 0; i < NUM_PORT; i++) begin
      logic hit;
      hit        = (grant_q == 4'(i));
      sel_tvalid = sel_tvalid | (axis.s_axis_tvalid[i] & hit);
      sel_tlast  = sel_tlast  | (axis.s_axis_tlast[i]  & hit);
      sel_tdata  = sel_tdata  | (axis.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{hit}});
      sel_tkeep  = sel_tkeep  | (axis.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] & {KEEP_WIDTH{hit}});
      sel_size   = sel_size   | (axis.s_axis_tuser_size[i*16 +: 16] & {16{hit}});
      sel_src    = sel_src    | (axis.s_axis_tuser_src[i*16 +: 16]  & {16{hit}});
      sel_dst    = sel_dst    | (axis.s_axis_tuser_dst[i*16 +: 16]  & {16{hit}});
    end
  end

  // FSM next state, grant bookkeeping and handshake outputs
  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    last_grant_d       = last_grant_q;
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tlast  = 1'b0;
    axis.s_axis_tready = '0;
    busy               = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_en && rr_found) begin
          state_d = ST_XFER;
          grant_d = rr_pick;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        busy               = 1'b1;
        axis.m_axis_tvalid = sel_tvalid;
        axis.m_axis_tlast  = sel_tlast;
        for (int i = 0; i < NUM_PORT; i++) begin
          axis.s_axis_tready[i] = axis.m_axis_tready & (grant_q == 4'(i));
        end
        if (last_beat) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Data and sideband follow the granted port with no added latency
  always_comb begin
    axis.m_axis_tdata      = sel_tdata;
    axis.m_axis_tkeep      = sel_tkeep;
    axis.m_axis_tuser_size = sel_size;
    axis.m_axis_tuser_src  = sel_src;
    axis.m_axis_tuser_dst  = sel_dst;
    m_axis_port            = grant_q;
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge axis_aclk or negedge box_rstn) begin
    if (!box_rstn) begin
      state_q      <= ST_IDLE;
      grant_q      <= 4'd0;
      last_grant_q <= LAST_GRANT_INIT;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef PORT_ARB_STATS_EN
  logic [31:0] pkt_cnt_q [NUM_PORT];

  // Per-port packet counters, bumped on each completed packet (wraps)
  always_ff @(posedge axis_aclk or negedge box_rstn) begin
    if (!box_rstn) begin
      for (int i = 0; i < NUM_PORT; i++) begin
        pkt_cnt_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NUM_PORT; i++) begin
        if (last_beat && (grant_q == 4'(i))) begin
          pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
        end else begin
          pkt_cnt_q[i] <= pkt_cnt_q[i];
        end
      end
    end
  end

  // Flatten the counters onto the output vector
  always_comb begin
    pkt_cnt = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      pkt_cnt[i*32 +: 32] = pkt_cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_axis_port_rr_arbiter.sv
// Self-checking bench for axis_port_rr_arbiter: randomized packet sources,
// a transaction-level round-robin reference model and an output scoreboard.
`timescale 1ns/1ps
module tb_axis_port_rr_arbiter;

  localparam int NP = 2;
  localparam int DW = 512;
  localparam int KW = 64;

  logic       axis_aclk = 1'b0;
  logic       box_rstn;
  logic       arb_en;
  logic [3:0] m_axis_port;
  logic       busy;
`ifdef PORT_ARB_STATS_EN
  logic [32*NP-1:0] pkt_cnt;
`endif

  always #5 axis_aclk = ~axis_aclk;

  axis_port_rr_arbiter_if #(.NUM_PORT(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus ();

  axis_port_rr_arbiter #(.NUM_PORT(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .axis_aclk   (axis_aclk),
    .box_rstn    (box_rstn),
    .axis        (bus),
    .arb_en      (arb_en),
    .m_axis_port (m_axis_port),
    .busy        (busy)
`ifdef PORT_ARB_STATS_EN
    ,
    .pkt_cnt     (pkt_cnt)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [15:0]   size;
    logic [15:0]   src;
    logic [15:0]   dst;
  } beat_t;

  beat_t   src_q [NP][$];   // beats still to be offered by each source
  beat_t   exp_q [NP][$];   // scoreboard: beats expected out, per port
  int      grant_log[$];
  int      grant_cyc[$];

  int      n_checks = 0;
  int      n_fail   = 0;

  // reference model (transaction level)
  bit      mdl_busy  = 1'b0;
  int      mdl_grant = 0;
  int      mdl_last  = NP - 1;
  int      beats_seen = 0;
  int      cyc = 0;
  logic [NP-1:0] fire = '0;

  // stimulus knobs
  int      valid_pct = 100;
  int      rdy_mode  = 0;    // 0: always ready, 1: toggle, 2: random
  bit      rdy_tog   = 1'b1;
  bit      en_rand   = 1'b0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: model the arbiter's packet-level behaviour and score output beats
  always @(negedge axis_aclk) begin
    beat_t         e;
    logic [NP-1:0] er;
    int            c;
    bit            found;
    if (!box_rstn) begin
      mdl_busy  = 1'b0;
      mdl_grant = 0;
      mdl_last  = NP - 1;
      fire      = '0;
    end else begin
      cyc++;
      fire = bus.s_axis_tvalid & bus.s_axis_tready;
      chk("m_axis_port", m_axis_port, mdl_grant);
      if (!mdl_busy) begin
        chk("idle_m_tvalid", bus.m_axis_tvalid, 0);
        chk("idle_s_tready", bus.s_axis_tready, 0);
        chk("idle_busy", busy, 0);
        if (arb_en && (|bus.s_axis_tvalid)) begin
          found = 1'b0;
          for (int k = 1; k <= NP; k++) begin
            c = (mdl_last + k) % NP;
            if (!found && bus.s_axis_tvalid[c]) begin
              found     = 1'b1;
              mdl_grant = c;
            end
          end
          mdl_busy = 1'b1;
          grant_log.push_back(mdl_grant);
          grant_cyc.push_back(cyc);
        end
      end else begin
        er = '0;
        if (bus.m_axis_tready) er[mdl_grant] = 1'b1;
        chk("xfer_busy", busy, 1);
        chk("xfer_s_tready", bus.s_axis_tready, er);
        chk("xfer_m_tvalid", bus.m_axis_tvalid, bus.s_axis_tvalid[mdl_grant]);
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          beats_seen++;
          if (exp_q[mdl_grant].size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q[mdl_grant].pop_front();
            chk("beat_data", bus.m_axis_tdata, e.data);
            chk("beat_keep", bus.m_axis_tkeep, e.keep);
            chk("beat_last", bus.m_axis_tlast, e.last);
            chk("beat_size", bus.m_axis_tuser_size, e.size);
            chk("beat_src",  bus.m_axis_tuser_src,  e.src);
            chk("beat_dst",  bus.m_axis_tuser_dst,  e.dst);
            if (e.last) begin
              mdl_busy = 1'b0;
              mdl_last = mdl_grant;
            end
          end
        end
      end
    end
  end

  task automatic add_pkt(input int p, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
      b.keep = {$urandom, $urandom};
      b.last = (i == nbeats - 1);
      b.size = 16'($urandom);
      b.src  = 16'(p);
      b.dst  = 16'($urandom);
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0 && $urandom_range(99) < valid_pct) begin
        b = src_q[p][0];
        bus.s_axis_tvalid[p]             = 1'b1;
        bus.s_axis_tdata[p*DW +: DW]     = b.data;
        bus.s_axis_tkeep[p*KW +: KW]     = b.keep;
        bus.s_axis_tlast[p]              = b.last;
        bus.s_axis_tuser_size[p*16 +: 16] = b.size;
        bus.s_axis_tuser_src[p*16 +: 16]  = b.src;
        bus.s_axis_tuser_dst[p*16 +: 16]  = b.dst;
      end else begin
        bus.s_axis_tvalid[p] = 1'b0;
      end
    end
    case (rdy_mode)
      1:       begin bus.m_axis_tready = rdy_tog; rdy_tog = ~rdy_tog; end
      2:       bus.m_axis_tready = ($urandom_range(99) < 70);
      default: bus.m_axis_tready = 1'b1;
    endcase
    if (en_rand) arb_en = ($urandom_range(99) < 80);
  endtask

  // One clock: retire accepted beats, then present the next stimulus
  task automatic step();
    @(posedge axis_aclk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (fire[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    end
    drive();
  endtask

  function automatic bit all_done();
    bit d = !mdl_busy;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() != 0 || exp_q[p].size() != 0) d = 1'b0;
    end
    return d;
  endfunction

  task automatic wait_drain(input int max_cyc, input string name);
    int n = 0;
    while (!all_done() && n < max_cyc) begin
      step();
      n++;
    end
    chk({name, "_drain_timeout"}, (n >= max_cyc), 0);
  endtask

  task automatic wait_beats(input int target, input int max_cyc);
    int n = 0;
    while (beats_seen < target && n < max_cyc) begin
      step();
      n++;
    end
    chk("wait_beats_timeout", (n >= max_cyc), 0);
  endtask

  task automatic check_grants(input string name, input int exp_g[$], input int exp_gap);
    chk({name, "_grant_count"}, grant_log.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++) begin
      chk({name, "_grant"}, grant_log[i], exp_g[i]);
      if (i > 0 && exp_gap > 0) chk({name, "_grant_spacing"}, grant_cyc[i] - grant_cyc[i-1], exp_gap);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b0;
    box_rstn               = 1'b0;
    arb_en                 = 1'b1;
    bus.s_axis_tvalid      = '0;
    bus.s_axis_tdata       = '0;
    bus.s_axis_tkeep       = '0;
    bus.s_axis_tlast       = '0;
    bus.s_axis_tuser_size  = '0;
    bus.s_axis_tuser_src   = '0;
    bus.s_axis_tuser_dst   = '0;
    bus.m_axis_tready      = 1'b1;
    repeat (3) @(posedge axis_aclk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
    chk("rst_s_tready", bus.s_axis_tready, 0);
    chk("rst_m_axis_port", m_axis_port, 0);
    box_rstn = 1'b1;
    step();

    // Both ports always valid, 3-beat packets: strict alternation
    clear_logs();
    add_pkt(0, 3); add_pkt(0, 3); add_pkt(1, 3); add_pkt(1, 3);
    drive();
    wait_drain(200, "alt");
    check_grants("alt", '{0, 1, 0, 1}, 4);

    // Port 1 alone, single-beat packets: one idle cycle between each
    clear_logs();
    repeat (4) add_pkt(1, 1);
    drive();
    wait_drain(200, "single");
    check_grants("single", '{1, 1, 1, 1}, 2);

    // Downstream ready toggling on a 5-beat packet; port 1 waits its turn
    clear_logs();
    rdy_mode = 1;
    add_pkt(0, 5); add_pkt(1, 2);
    drive();
    wait_drain(200, "toggle");
    check_grants("toggle", '{0, 1}, 0);
    rdy_mode = 0;

    // arb_en dropped during beat 2: packet completes, no further grants
    clear_logs();
    b0 = beats_seen;
    add_pkt(0, 4);
    drive();
    wait_beats(b0 + 1, 100);
    arb_en = 1'b0;
    add_pkt(1, 2);
    drive();
    repeat (12) step();
    chk("en_off_busy", busy, 0);
    chk("en_off_m_tvalid", bus.m_axis_tvalid, 0);
    chk("en_off_grants", grant_log.size(), 1);
    chk("en_off_port1_pending", src_q[1].size(), 2);
    arb_en = 1'b1;
    wait_drain(200, "en_on");
    check_grants("en", '{0, 1}, 0);

    // Reset during beat 2 of a port 1 packet
    clear_logs();
    b0 = beats_seen;
    add_pkt(1, 4);
    drive();
    wait_beats(b0 + 1, 100);
    box_rstn = 1'b0;
    #1;
    chk("arst_m_tvalid", bus.m_axis_tvalid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_s_tready", bus.s_axis_tready, 0);
    chk("arst_m_axis_port", m_axis_port, 0);
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
    end
    drive();
    repeat (2) step();
    box_rstn = 1'b1;
    clear_logs();
    add_pkt(0, 2); add_pkt(1, 2);
    drive();
    wait_drain(200, "post_rst");
    check_grants("post_rst", '{0, 1}, 0);

    // Random traffic: random lengths, valid gaps, backpressure, arb_en
    clear_logs();
    valid_pct = 70;
    rdy_mode  = 2;
    en_rand   = 1'b1;
    for (int i = 0; i < 40; i++) add_pkt($urandom_range(NP - 1), $urandom_range(5, 1));
    drive();
    wait_drain(4000, "random");
    en_rand   = 1'b0;
    arb_en    = 1'b1;
    valid_pct = 100;
    rdy_mode  = 0;
    wait_drain(200, "random_tail");

`ifdef PORT_ARB_STATS_EN
    // Counter wrap from all-ones
    force dut.pkt_cnt_q[0] = 32'hFFFF_FFFF;
    step();
    release dut.pkt_cnt_q[0];
    add_pkt(0, 2);
    drive();
    wait_drain(100, "stats");
    step();
    chk("pkt_cnt0_wrap", pkt_cnt[31:0], 32'd0);
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
